// File: rtl/if_id_queue.sv
// ============================================================================
// Module   : if_id_queue
// Brief    : Instruction fetch queue between fetch and decode. A small FIFO of
//            (pc, instruction) pairs with valid/ready on both sides and flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_queue #(
    parameter int          DEPTH    = 4,
    parameter int          AW       = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    // fetch side
    input  logic          in_valid,
    input  logic [31:0]   in_pc,
    input  logic [31:0]   in_inst,
    output logic          in_ready,
    // redirect
    input  logic          flush,
    // decode side
    output logic          id_valid,
    output logic [31:0]   id_pc,
    output logic [31:0]   id_inst,
    input  logic          id_ready,
    output logic [AW:0]   count
);

    // Storage carries no reset: contents are only observed through valid entries.
    logic [31:0] r_pc_mem   [DEPTH];
    logic [31:0] r_inst_mem [DEPTH];

    logic [AW:0] r_rd_ptr;
    logic [AW:0] r_wr_ptr;

    logic        w_empty;
    logic        w_full;
    logic        w_push;
    logic        w_pop;

    assign w_empty = (r_rd_ptr == r_wr_ptr);
    assign w_full  = (r_rd_ptr[AW-1:0] == r_wr_ptr[AW-1:0]) &&
                     (r_rd_ptr[AW] != r_wr_ptr[AW]);

    // Full blocks pushes even when a pop happens on the same edge.
    assign w_push  = in_valid & ~w_full & ~flush;
    assign w_pop   = ~w_empty & id_ready & ~flush;

    assign in_ready = ~w_full;
    assign id_valid = ~w_empty;
    assign id_pc    = w_empty ? 32'h0000_0000 : r_pc_mem[r_rd_ptr[AW-1:0]];
    assign id_inst  = w_empty ? NOP_INST      : r_inst_mem[r_rd_ptr[AW-1:0]];
    assign count    = r_wr_ptr - r_rd_ptr;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr[AW-1:0]]   <= in_pc;
            r_inst_mem[r_wr_ptr[AW-1:0]] <= in_inst;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (flush) begin
            // Everything queued is wrong-path: drop it by catching up the read side.
            r_rd_ptr <= r_wr_ptr;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_if_id_queue.sv
// ============================================================================
// Module   : tb_if_id_queue
// Brief    : Directed self-checking bench for if_id_queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_id_queue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        in_ready;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_ready;
    logic [2:0]  count;

    int n_cmp;
    int n_err;

    if_id_queue #(.DEPTH(4), .AW(2), .NOP_INST(32'h0000_0000)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_pc    (in_pc),
        .in_inst  (in_inst),
        .in_ready (in_ready),
        .flush    (flush),
        .id_valid (id_valid),
        .id_pc    (id_pc),
        .id_inst  (id_inst),
        .id_ready (id_ready),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_push(input logic v, input logic [31:0] pc);
        in_valid = v;
        in_pc    = pc;
        in_inst  = inst_of(pc);
    endtask

    task automatic test_reset();
        n_cmp++; if (count !== 3'd0)        begin n_err++; $display("FAIL rst_count: got %0d expected 0", count); end
        n_cmp++; if (in_ready !== 1'b1)     begin n_err++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
        drive_push(1'b1, 32'h100);
        step();
        drive_push(1'b0, 32'h0);
        n_cmp++; if (count !== 3'd1)        begin n_err++; $display("FAIL pre_rst_count: got %0d expected 1", count); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (id_valid !== 1'b0)     begin n_err++; $display("FAIL async_rst_valid: got %b expected 0", id_valid); end
        n_cmp++; if (id_inst !== 32'h0)     begin n_err++; $display("FAIL async_rst_inst: got %h expected 00000000", id_inst); end
        n_cmp++; if (id_pc !== 32'h0)       begin n_err++; $display("FAIL async_rst_pc: got %h expected 00000000", id_pc); end
        n_cmp++; if (count !== 3'd0)        begin n_err++; $display("FAIL async_rst_count: got %0d expected 0", count); end
        n_cmp++; if (in_ready !== 1'b1)     begin n_err++; $display("FAIL async_rst_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_stream();
        logic [31:0] pcs [3];
        pcs[0] = 32'h00; pcs[1] = 32'h04; pcs[2] = 32'h08;
        id_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_push(1'b1, pcs[i]);
            if (i == 0) begin
                n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL stream_no_fallthrough: got %b expected 0", id_valid); end
            end
            step();
            n_cmp++; if (id_pc !== pcs[i])            begin n_err++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, id_pc, pcs[i]); end
            n_cmp++; if (id_inst !== inst_of(pcs[i])) begin n_err++; $display("FAIL stream_inst[%0d]: got %h expected %h", i, id_inst, inst_of(pcs[i])); end
            n_cmp++; if (count !== 3'd1)              begin n_err++; $display("FAIL stream_count[%0d]: got %0d expected 1", i, count); end
        end
        drive_push(1'b0, 32'h0);
        step();
        n_cmp++; if (id_valid !== 1'b0)   begin n_err++; $display("FAIL stream_drained_valid: got %b expected 0", id_valid); end
        n_cmp++; if (id_inst !== 32'h0)   begin n_err++; $display("FAIL stream_drained_nop: got %h expected 00000000", id_inst); end
    endtask

    task automatic test_fill();
        id_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_push(1'b1, 32'h10 + 32'(4 * i));
            step();
        end
        n_cmp++; if (count !== 3'd4)      begin n_err++; $display("FAIL fill_count: got %0d expected 4", count); end
        n_cmp++; if (in_ready !== 1'b0)   begin n_err++; $display("FAIL fill_in_ready: got %b expected 0", in_ready); end
        drive_push(1'b1, 32'h99);
        step();
        n_cmp++; if (count !== 3'd4)      begin n_err++; $display("FAIL fill_fifth_count: got %0d expected 4", count); end
        n_cmp++; if (id_pc !== 32'h10)    begin n_err++; $display("FAIL fill_head: got %h expected 00000010", id_pc); end
    endtask

    task automatic test_full_pop();
        logic [31:0] exp [4];
        exp[0] = 32'h14; exp[1] = 32'h18; exp[2] = 32'h1C; exp[3] = 32'h30;
        id_ready = 1'b1;
        drive_push(1'b1, 32'h30);
        step();
        n_cmp++; if (count !== 3'd3)      begin n_err++; $display("FAIL fullpop_count: got %0d expected 3", count); end
        n_cmp++; if (id_pc !== 32'h14)    begin n_err++; $display("FAIL fullpop_head: got %h expected 00000014", id_pc); end
        n_cmp++; if (in_ready !== 1'b1)   begin n_err++; $display("FAIL fullpop_ready: got %b expected 1", in_ready); end
        id_ready = 1'b0;
        step();
        drive_push(1'b0, 32'h0);
        n_cmp++; if (count !== 3'd4)      begin n_err++; $display("FAIL fullpop_accept: got %0d expected 4", count); end
        id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (id_pc !== exp[i])            begin n_err++; $display("FAIL drain_pc[%0d]: got %h expected %h", i, id_pc, exp[i]); end
            n_cmp++; if (id_inst !== inst_of(exp[i])) begin n_err++; $display("FAIL drain_inst[%0d]: got %h expected %h", i, id_inst, inst_of(exp[i])); end
            step();
        end
        n_cmp++; if (count !== 3'd0)      begin n_err++; $display("FAIL drain_count: got %0d expected 0", count); end
    endtask

    task automatic test_flush();
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_push(1'b1, 32'h50 + 32'(4 * i));
            step();
        end
        n_cmp++; if (count !== 3'd3)      begin n_err++; $display("FAIL flush_pre_count: got %0d expected 3", count); end
        flush = 1'b1;
        id_ready = 1'b1;
        drive_push(1'b1, 32'h20);
        step();
        flush = 1'b0;
        id_ready = 1'b0;
        n_cmp++; if (count !== 3'd0)      begin n_err++; $display("FAIL flush_count: got %0d expected 0", count); end
        n_cmp++; if (id_valid !== 1'b0)   begin n_err++; $display("FAIL flush_valid: got %b expected 0", id_valid); end
        n_cmp++; if (id_inst !== 32'h0)   begin n_err++; $display("FAIL flush_nop: got %h expected 00000000", id_inst); end
        n_cmp++; if (in_ready !== 1'b1)   begin n_err++; $display("FAIL flush_ready: got %b expected 1", in_ready); end
        drive_push(1'b1, 32'h40);
        step();
        drive_push(1'b0, 32'h0);
        n_cmp++; if (id_pc !== 32'h40)    begin n_err++; $display("FAIL flush_redirect_head: got %h expected 00000040", id_pc); end
        n_cmp++; if (count !== 3'd1)      begin n_err++; $display("FAIL flush_redirect_count: got %0d expected 1", count); end
        // Multi-cycle flush keeps the queue empty and drops every offered push.
        flush = 1'b1;
        drive_push(1'b1, 32'h44);
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++; if (count !== 3'd0)  begin n_err++; $display("FAIL flush_hold_count[%0d]: got %0d expected 0", i, count); end
        end
        flush = 1'b0;
        drive_push(1'b1, 32'h60);
        step();
        drive_push(1'b0, 32'h0);
        n_cmp++; if (id_pc !== 32'h60)    begin n_err++; $display("FAIL flush_hold_head: got %h expected 00000060", id_pc); end
        n_cmp++; if (count !== 3'd1)      begin n_err++; $display("FAIL flush_hold_after_count: got %0d expected 1", count); end
        id_ready = 1'b1;
        step();
    endtask

    task automatic test_wrap();
        int          next_push;
        int          next_pop;
        logic [31:0] exp_pc;
        next_push = 0;
        next_pop  = 0;
        for (int cyc = 0; cyc < 80 && next_pop < 10; cyc++) begin
            id_ready = (cyc % 3) != 0;
            drive_push(next_push < 10, 32'h200 + 32'(4 * next_push));
            if (id_valid && id_ready) begin
                exp_pc = 32'h200 + 32'(4 * next_pop);
                n_cmp++; if (id_pc !== exp_pc) begin n_err++; $display("FAIL wrap_pc[%0d]: got %h expected %h", next_pop, id_pc, exp_pc); end
                next_pop++;
            end
            if (in_valid && in_ready) next_push++;
            step();
        end
        drive_push(1'b0, 32'h0);
        n_cmp++; if (next_pop !== 10)     begin n_err++; $display("FAIL wrap_pops: got %0d expected 10", next_pop); end
        n_cmp++; if (count !== 3'd0)      begin n_err++; $display("FAIL wrap_final_count: got %0d expected 0", count); end
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b1;
        flush    = 1'b0;
        id_ready = 1'b0;
        in_valid = 1'b0;
        in_pc    = 32'h0;
        in_inst  = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_stream();
        test_fill();
        test_full_pop();
        test_flush();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
